vend_credit_fsm: RTL and testbench



---
 rtl/vend_credit_fsm.sv | 167 ++++++++++++++++
 tb/tb_vend_credit_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_fsm.sv
// Multi-item vending controller: one credit accumulator in 5-rupee units, a packed
// per-item price table, cancel/refund, an overflow guard and coin-by-coin change return.
module vend_credit_fsm #(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            PRICE_W    = 4,
    parameter logic [NUM_ITEMS*PRICE_W-1:0]  PRICES     = 16'h6543,
    parameter int                            MAX_CREDIT = 15,
    parameter int                            CREDIT_W   = 5,
    parameter int                            SEL_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    item_sel,
    input  logic                coin_5,
    input  logic                coin_10,
    input  logic                cancel,
    input  logic                chg_ack,
    output logic                product,
    output logic [SEL_W-1:0]    product_id,
    output logic                chg_coin,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // One spare bit so credit + coin value can be compared against the limit without wrapping.
    localparam int SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    function automatic logic [SUM_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        logic [SUM_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            p = (idx == SEL_W'(i)) ? SUM_W'(PRICES[i*PRICE_W +: PRICE_W]) : p;
        end
        return p;
    endfunction

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                product_q, product_d;
    logic [SEL_W-1:0]    product_id_q, product_id_d;
    logic                chg_coin_q, chg_coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [SUM_W-1:0]    coin_val_s;
    logic                coin_any_s;
    logic [SUM_W-1:0]    credit_sum_s;
    logic [SUM_W-1:0]    price_s;
    logic [SUM_W-1:0]    price_new_s;
    logic                sel_valid_s;
    logic [SUM_W-1:0]    max_credit_s;

    // Both coin pulses in one cycle add up: {coin_10, coin_5} is exactly 2*coin_10 + coin_5.
    assign coin_val_s   = SUM_W'({coin_10, coin_5});
    assign coin_any_s   = coin_5 | coin_10;
    assign credit_sum_s = {1'b0, credit_q} + coin_val_s;
    assign price_s      = price_of(sel_q);
    assign price_new_s  = price_of(item_sel);
    assign sel_valid_s  = ({1'b0, item_sel} < (SEL_W+1)'(NUM_ITEMS));
    assign max_credit_s = SUM_W'(MAX_CREDIT);

    // Next-state, credit and registered-output decode.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_d         = sel_q;
        coin_reject_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (coin_any_s) begin
                    if (!sel_valid_s || (coin_val_s > max_credit_s)) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        sel_d    = item_sel;
                        credit_d = coin_val_s[CREDIT_W-1:0];
                        state_d  = (coin_val_s >= price_new_s) ? S_VEND : S_COLLECT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_any_s;
                    state_d       = (credit_q != CREDIT_W'(0)) ? S_REFUND : S_IDLE;
                end else if (credit_sum_s > max_credit_s) begin
                    coin_reject_d = 1'b1;
                end else begin
                    credit_d = credit_sum_s[CREDIT_W-1:0];
                    state_d  = (credit_sum_s >= price_s) ? S_VEND : S_COLLECT;
                end
            end
            S_VEND: begin
                coin_reject_d = coin_any_s;
                if ({1'b0, credit_q} > price_s) begin
                    credit_d = credit_q - price_s[CREDIT_W-1:0];
                    state_d  = S_REFUND;
                end else begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end
            end
            S_REFUND: begin
                coin_reject_d = coin_any_s;
                if (credit_q == CREDIT_W'(0)) begin
                    state_d = S_IDLE;
                end else if (chg_coin_q && chg_ack) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    state_d  = (credit_q == CREDIT_W'(1)) ? S_IDLE : S_REFUND;
                end else begin
                    state_d = S_REFUND;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state they describe.
        product_d    = (state_d == S_VEND);
        product_id_d = (state_d == S_VEND) ? sel_d : product_id_q;
        chg_coin_d   = (state_d == S_REFUND) && (credit_d != CREDIT_W'(0));
        busy_d       = (state_d != S_IDLE);
    end

    // State, credit and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            sel_q         <= '0;
            product_q     <= 1'b0;
            product_id_q  <= '0;
            chg_coin_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            product_q     <= product_d;
            product_id_q  <= product_id_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign product     = product_q;
    assign product_id  = product_id_q;
    assign chg_coin    = chg_coin_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: two instances (default table, and a 3-item table with a 15-unit
// item 0) share the same stimulus and are compared every cycle against a purchase model.
module tb_vend_credit_fsm;

    localparam int MAXC = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] item_sel;
    logic       coin_5, coin_10, cancel, chg_ack;

    logic       a_product, a_chg_coin, a_coin_reject, a_busy;
    logic [1:0] a_product_id;
    logic [4:0] a_credit;
    logic       b_product, b_chg_coin, b_coin_reject, b_busy;
    logic [1:0] b_product_id;
    logic [4:0] b_credit;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vend_credit_fsm dut_a (
        .clk(clk), .rst_n(rst_n), .item_sel(item_sel), .coin_5(coin_5), .coin_10(coin_10),
        .cancel(cancel), .chg_ack(chg_ack), .product(a_product), .product_id(a_product_id),
        .chg_coin(a_chg_coin), .coin_reject(a_coin_reject), .credit(a_credit), .busy(a_busy)
    );

    vend_credit_fsm #(.NUM_ITEMS(3), .PRICES(12'h54F)) dut_b (
        .clk(clk), .rst_n(rst_n), .item_sel(item_sel), .coin_5(coin_5), .coin_10(coin_10),
        .cancel(cancel), .chg_ack(chg_ack), .product(b_product), .product_id(b_product_id),
        .chg_coin(b_chg_coin), .coin_reject(b_coin_reject), .credit(b_credit), .busy(b_busy)
    );

    // Purchase in progress: credit held, chosen item, and which phase of the purchase we are in.
    typedef struct {
        int credit;
        int sel;
        bit collecting;
        bit vending;
        bit refunding;
        bit rejected;
    } mdl_t;

    mdl_t ma, mb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int price_at(input logic [15:0] prices, input int idx);
        return int'((prices >> (4 * idx)) & 16'h000F);
    endfunction

    task automatic mstep(inout mdl_t m, input int nitems, input logic [15:0] prices,
                         input int s, input int c5, input int c10, input int cx, input int ack);
        int cv;
        cv = c5 + 2 * c10;
        m.rejected = 1'b0;
        if (m.vending) begin
            m.rejected  = (cv > 0);
            m.credit    = m.credit - price_at(prices, m.sel);
            m.vending   = 1'b0;
            m.refunding = (m.credit > 0);
        end else if (m.refunding) begin
            m.rejected = (cv > 0);
            if (ack != 0 && m.credit > 0) m.credit = m.credit - 1;
            if (m.credit == 0) m.refunding = 1'b0;
        end else if (m.collecting) begin
            if (cx != 0) begin
                m.rejected   = (cv > 0);
                m.collecting = 1'b0;
                m.refunding  = (m.credit > 0);
            end else if (m.credit + cv > MAXC) begin
                m.rejected = 1'b1;
            end else begin
                m.credit = m.credit + cv;
                if (m.credit >= price_at(prices, m.sel)) begin
                    m.collecting = 1'b0;
                    m.vending    = 1'b1;
                end
            end
        end else if (cv > 0) begin
            if (s >= nitems) begin
                m.rejected = 1'b1;
            end else begin
                m.sel    = s;
                m.credit = cv;
                if (cv >= price_at(prices, s)) m.vending = 1'b1;
                else m.collecting = 1'b1;
            end
        end
    endtask

    task automatic cmp(input string pfx, input mdl_t m, input logic prod, input logic [1:0] pid,
                       input logic chg, input logic rej, input logic [4:0] cr, input logic bsy);
        chk({pfx, "_product"}, 32'(prod), 32'(m.vending));
        if (m.vending) chk({pfx, "_product_id"}, 32'(pid), 32'(m.sel));
        chk({pfx, "_chg_coin"}, 32'(chg), 32'(m.refunding && m.credit > 0));
        chk({pfx, "_coin_reject"}, 32'(rej), 32'(m.rejected));
        chk({pfx, "_credit"}, 32'(cr), 32'(m.credit));
        chk({pfx, "_busy"}, 32'(bsy), 32'(m.collecting || m.vending || m.refunding));
    endtask

    // One clock: drive at the falling edge, advance both models at the rising edge, compare 1 ns later.
    task automatic cyc(input logic c5, input logic c10, input logic cx, input logic ack, input logic [1:0] s);
        coin_5   = c5;
        coin_10  = c10;
        cancel   = cx;
        chg_ack  = ack;
        item_sel = s;
        @(posedge clk);
        mstep(ma, 4, 16'h6543, int'(s), int'(c5), int'(c10), int'(cx), int'(ack));
        mstep(mb, 3, 16'h054F, int'(s), int'(c5), int'(c10), int'(cx), int'(ack));
        #1;
        cmp("A", ma, a_product, a_product_id, a_chg_coin, a_coin_reject, a_credit, a_busy);
        cmp("B", mb, b_product, b_product_id, b_chg_coin, b_coin_reject, b_credit, b_busy);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        ma = '{default: 0};
        mb = '{default: 0};
        cmp("A_rst", ma, a_product, a_product_id, a_chg_coin, a_coin_reject, a_credit, a_busy);
        cmp("B_rst", mb, b_product, b_product_id, b_chg_coin, b_coin_reject, b_credit, b_busy);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {coin_5, coin_10, cancel, chg_ack} = 4'b0000;
        item_sel = 2'd0;
        ma = '{default: 0};
        mb = '{default: 0};
        @(negedge clk);
        do_reset();

        // Item 0 (price 3): 10 Rs then 5 Rs, exact money, no change.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t1_product", 32'(a_product), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t1_no_change", 32'(a_chg_coin), 32'd0);

        // Item 0 with 20 Rs: one unit of change handed back on ack.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t2_chg_coin", 32'(a_chg_coin), 32'd1);
        chk("t2_credit", 32'(a_credit), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        chk("t2_busy", 32'(a_busy), 32'd0);

        // Item 3 (price 6): both coins together, twice.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("t3_credit3", 32'(a_credit), 32'd3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        chk("t3_product_id", 32'(a_product_id), 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd3);

        // Cancel after 10 Rs, hopper stalls, a coin arrives mid-refund, then two acks.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        chk("t4_chg_hold", 32'(a_chg_coin), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        chk("t4_reject", 32'(a_coin_reject), 32'd1);
        chk("t4_credit", 32'(a_credit), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        chk("t4_idle", 32'(a_busy), 32'd0);

        // Instance B, item 0 costs 15: fill to 14, overflowing coin bounced, last 5 Rs buys it.
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("t5_overflow_reject", 32'(b_coin_reject), 32'd1);
        chk("t5_credit14", 32'(b_credit), 32'd14);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t5_product", 32'(b_product), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Out-of-range item on the 3-item instance; A accepts the same coin for item 3.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
        chk("t6_bad_sel_reject", 32'(b_coin_reject), 32'd1);
        chk("t6_bad_sel_idle", 32'(b_busy), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
        chk("t6_in_refund", 32'(a_chg_coin), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("t6_no_chg_after_rst", 32'(a_chg_coin), 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
                    ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 50),
                    2'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
